// File: rtl/pipe_repeater_chain.sv
// Pipelined repeater: a chain of STAGES two-entry skid slices with valid/ready handshake.
// Defining PIPE_REPEATER_OCC_EN adds a registered occupancy count port.
module pipe_repeater_chain #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
`ifdef PIPE_REPEATER_OCC_EN
  ,
  localparam int unsigned OCC_W = $clog2(2 * STAGES + 1)
`endif
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_REPEATER_OCC_EN
  ,
  output logic [OCC_W-1:0] occupancy
`endif
);

  if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
    $error("pipe_repeater_chain: WIDTH out of range");
  end
  if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
    $error("pipe_repeater_chain: STAGES out of range");
  end

  // Link k is the handshake between stage k-1 and stage k.
  logic [STAGES:0] link_valid;
  logic [STAGES:0] link_ready;
  logic [WIDTH-1:0] link_data [STAGES+1];

  assign link_valid[0]      = in_valid;
  assign link_data[0]       = in_data;
  assign in_ready           = link_ready[0];
  assign out_valid          = link_valid[STAGES];
  assign out_data           = link_data[STAGES];
  assign link_ready[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             m_v_q, s_v_q;
    logic [WIDTH-1:0] m_d_q, s_d_q;
    logic             up_xfer, dn_take;
    logic             load_m_skid, load_m_up, load_s;

    // Ready comes straight from the skid flag so no combinational path spans stages.
    assign link_ready[k]     = ~s_v_q;
    assign link_valid[k + 1] = m_v_q;
    assign link_data[k + 1]  = m_d_q;

    always_comb begin
      up_xfer     = link_valid[k] & ~s_v_q;
      dn_take     = m_v_q & link_ready[k + 1];
      load_m_skid = dn_take & s_v_q;
      load_m_up   = up_xfer & (dn_take | ~m_v_q);
      load_s      = up_xfer & m_v_q & ~dn_take;
    end

    always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
        m_v_q <= 1'b0;
        s_v_q <= 1'b0;
      end else if (dn_take) begin
        if (s_v_q) begin
          s_v_q <= 1'b0;
        end else if (!up_xfer) begin
          m_v_q <= 1'b0;
        end
      end else if (up_xfer) begin
        if (!m_v_q) begin
          m_v_q <= 1'b1;
        end else begin
          s_v_q <= 1'b1;
        end
      end
    end

    // Data registers load only on transfer and carry no reset.
    always_ff @(posedge CK) begin
      if (load_m_skid) begin
        m_d_q <= s_d_q;
      end else if (load_m_up) begin
        m_d_q <= link_data[k];
      end
      if (load_s) begin
        s_d_q <= link_data[k];
      end
    end
  end

`ifdef PIPE_REPEATER_OCC_EN
  logic             occ_in_x, occ_out_x;
  logic [OCC_W-1:0] occ_q;

  assign occ_in_x  = in_valid & in_ready;
  assign occ_out_x = out_valid & out_ready;
  assign occupancy = occ_q;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      occ_q <= '0;
    end else if (occ_in_x && !occ_out_x) begin
      occ_q <= occ_q + OCC_W'(1);
    end else if (!occ_in_x && occ_out_x) begin
      occ_q <= occ_q - OCC_W'(1);
    end
  end

  occ_bound_a: assert property (@(posedge CK) disable iff (!RN) occ_q <= OCC_W'(2 * STAGES));
`endif

endmodule
